// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control-bundle widths, EX field positions and the
// default datapath width.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam int EX_W = 3;
  localparam int M_W  = 3;
  localparam int WB_W = 2;

  // EX bundle layout: {ALUSrc, ALUOp[1:0]}
  localparam int ALUSRC_BIT = 2;
  localparam int ALUOP_MSB  = 1;
  localparam int ALUOP_LSB  = 0;
  localparam int ALUOP_W    = ALUOP_MSB - ALUOP_LSB + 1;

endpackage

// File: rtl/pipe_reg.sv
// W-bit pipeline flop with synchronous active-high clear; a cleared control
// field reads as a bubble downstream.
module pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (reset) q_q <= '0;
    else       q_q <= d_i;
  end

  assign q_o = q_q;

endmodule

// File: rtl/id_ex_module.sv
// ID/EX pipeline register: captures decode-stage control and data every cycle
// and presents it to execute one cycle later; EX is split into ALUSrc/ALUOp.
module id_ex_module
  import cpu_pkg::*;
#(
  parameter int width = XLEN
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [EX_W-1:0]    EX,
  input  logic [M_W-1:0]     M,
  input  logic [WB_W-1:0]    WB,
  input  logic [width-1:0]   pcAddr,
  input  logic [width-1:0]   reg1,
  input  logic [width-1:0]   reg2,
  input  logic [width-1:0]   immediate,
  input  logic [width-1:0]   instruction,
  output logic               ALUSrcOut,
  output logic [ALUOP_W-1:0] ALUOpOut,
  output logic [M_W-1:0]     MOut,
  output logic [WB_W-1:0]    WBOut,
  output logic [width-1:0]   pcAddrOut,
  output logic [width-1:0]   immediateOut,
  output logic [width-1:0]   reg1Out,
  output logic [width-1:0]   reg2Out,
  output logic [width-1:0]   instructionOut
);

  // Control fields
  pipe_reg #(.W(1)) u_alusrc (
    .clk(clk), .reset(reset), .d_i(EX[ALUSRC_BIT]), .q_o(ALUSrcOut)
  );
  pipe_reg #(.W(ALUOP_W)) u_aluop (
    .clk(clk), .reset(reset), .d_i(EX[ALUOP_MSB:ALUOP_LSB]), .q_o(ALUOpOut)
  );
  pipe_reg #(.W(M_W)) u_m (
    .clk(clk), .reset(reset), .d_i(M), .q_o(MOut)
  );
  pipe_reg #(.W(WB_W)) u_wb (
    .clk(clk), .reset(reset), .d_i(WB), .q_o(WBOut)
  );

  // Datapath fields
  pipe_reg #(.W(width)) u_pc (
    .clk(clk), .reset(reset), .d_i(pcAddr), .q_o(pcAddrOut)
  );
  pipe_reg #(.W(width)) u_reg1 (
    .clk(clk), .reset(reset), .d_i(reg1), .q_o(reg1Out)
  );
  pipe_reg #(.W(width)) u_reg2 (
    .clk(clk), .reset(reset), .d_i(reg2), .q_o(reg2Out)
  );
  pipe_reg #(.W(width)) u_imm (
    .clk(clk), .reset(reset), .d_i(immediate), .q_o(immediateOut)
  );
  pipe_reg #(.W(width)) u_instr (
    .clk(clk), .reset(reset), .d_i(instruction), .q_o(instructionOut)
  );

endmodule

// File: tb/tb_id_ex_module.sv
// Scoreboard bench for id_ex_module: the driver queues the expected register
// contents per edge, a negedge monitor pops and compares.
module tb_id_ex_module;

  logic        clk;
  logic        reset;
  logic [2:0]  EX;
  logic [2:0]  M;
  logic [1:0]  WB;
  logic [31:0] pcAddr, reg1, reg2, immediate, instruction;
  logic        ALUSrcOut;
  logic [1:0]  ALUOpOut;
  logic [2:0]  MOut;
  logic [1:0]  WBOut;
  logic [31:0] pcAddrOut, immediateOut, reg1Out, reg2Out, instructionOut;

  id_ex_module #(.width(32)) dut (
    .clk(clk), .reset(reset),
    .EX(EX), .M(M), .WB(WB),
    .pcAddr(pcAddr), .reg1(reg1), .reg2(reg2),
    .immediate(immediate), .instruction(instruction),
    .ALUSrcOut(ALUSrcOut), .ALUOpOut(ALUOpOut), .MOut(MOut), .WBOut(WBOut),
    .pcAddrOut(pcAddrOut), .immediateOut(immediateOut),
    .reg1Out(reg1Out), .reg2Out(reg2Out), .instructionOut(instructionOut)
  );

  typedef struct packed {
    logic        alusrc;
    logic [1:0]  aluop;
    logic [2:0]  m;
    logic [1:0]  wb;
    logic [31:0] pc;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic [31:0] ins;
  } out_t;

  out_t  exp_q[$];
  string name_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: mid-cycle, compare the registered outputs against the oldest expectation
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      out_t  e;
      out_t  a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = '{ALUSrcOut, ALUOpOut, MOut, WBOut, pcAddrOut, reg1Out, reg2Out,
            immediateOut, instructionOut};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s: got %h, expected %h", n, a, e);
      end
    end
  end

  // Drive one edge's inputs and queue the hand-computed register contents
  task automatic step(input string n, input logic rst, input logic [2:0] ex,
                      input logic [2:0] m, input logic [1:0] wb,
                      input logic [31:0] pc, input logic [31:0] r1,
                      input logic [31:0] r2, input logic [31:0] imm,
                      input logic [31:0] ins, input out_t e);
    @(negedge clk);
    #1;
    reset = rst; EX = ex; M = m; WB = wb;
    pcAddr = pc; reg1 = r1; reg2 = r2; immediate = imm; instruction = ins;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  localparam out_t ZERO  = '0;
  localparam out_t VEC_A = '{1'b1, 2'b01, 3'b111, 2'b11, 32'h1, 32'h2, 32'h3,
                             32'h4, 32'h5};
  localparam out_t VEC_D = '{1'b1, 2'b01, 3'b111, 2'b11, 32'h1, 32'hDEADBEEF,
                             32'h3, 32'h4, 32'h5};

  initial begin
    reset = 1'b1;
    EX = 'x; M = 'x; WB = 'x;
    pcAddr = 'x; reg1 = 'x; reg2 = 'x; immediate = 'x; instruction = 'x;

    for (int i = 0; i < 6; i++)
      step("reset_x_inputs", 1'b1, 'x, 'x, 'x, 'x, 'x, 'x, 'x, 'x, ZERO);

    step("load_vec_a", 1'b0, 3'b101, 3'b111, 2'b11, 32'h1, 32'h2, 32'h3,
         32'h4, 32'h5, VEC_A);
    for (int i = 0; i < 10; i++)
      step("hold_vec_a", 1'b0, 3'b101, 3'b111, 2'b11, 32'h1, 32'h2, 32'h3,
           32'h4, 32'h5, VEC_A);

    // Input changes just after an edge must not reach the output before the next one
    @(posedge clk);
    #1;
    reg1 = 32'hDEADBEEF;
    #2;
    vectors++;
    if (reg1Out !== 32'h2) begin
      miscompares++;
      $display("FAIL midcycle_reg1: got %h, expected %h", reg1Out, 32'h2);
    end
    step("reg1_deadbeef", 1'b0, 3'b101, 3'b111, 2'b11, 32'h1, 32'hDEADBEEF,
         32'h3, 32'h4, 32'h5, VEC_D);

    step("ex_010", 1'b0, 3'b010, 3'b000, 2'b00, 32'h1, 32'h2, 32'h3, 32'h4,
         32'h5, '{1'b0, 2'b10, 3'b000, 2'b00, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5});
    step("ex_100", 1'b0, 3'b100, 3'b000, 2'b00, 32'h1, 32'h2, 32'h3, 32'h4,
         32'h5, '{1'b1, 2'b00, 3'b000, 2'b00, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5});

    step("all_ones", 1'b0, 3'b111, 3'b111, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF,
         32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, '1);
    step("alt_pattern", 1'b0, 3'b011, 3'b010, 2'b01, 32'h80000000, 32'hA5A5A5A5,
         32'h5A5A5A5A, 32'hFFFFF800, 32'h00500093,
         '{1'b0, 2'b11, 3'b010, 2'b01, 32'h80000000, 32'hA5A5A5A5, 32'h5A5A5A5A,
           32'hFFFFF800, 32'h00500093});
    step("distinct_fields", 1'b0, 3'b110, 3'b001, 2'b10, 32'h00000104,
         32'h11111111, 32'h22222222, 32'h00000010, 32'h00A10113,
         '{1'b1, 2'b10, 3'b001, 2'b10, 32'h00000104, 32'h11111111, 32'h22222222,
           32'h00000010, 32'h00A10113});

    // One-cycle reset with live inputs flushes to a bubble, then reloads
    step("midstream_reset", 1'b1, 3'b101, 3'b111, 2'b11, 32'h1, 32'h2, 32'h3,
         32'h4, 32'h5, ZERO);
    step("reload_after_reset", 1'b0, 3'b101, 3'b111, 2'b11, 32'h1, 32'h2,
         32'h3, 32'h4, 32'h5, VEC_A);

    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
